// File: rtl/alu_regfile_ctrl.sv
// alu_regfile_ctrl: multi-cycle sequencer for the 8-bit ALU / 4-entry
// register file datapath. It accepts one 18-bit instruction per valid/ready
// handshake and walks it through IDLE -> DECODE -> EXEC -> WB/BRANCH.
// Every datapath control is a register that is loaded with the value that
// belongs to the state being entered, so the outputs track the state without
// any combinational path to the ports.
// Optional build macro: OVF_TRAP_EN adds the ovf_trap output. When it is set,
// an overflowing R/I result is dropped and signalled instead of written.
module alu_regfile_ctrl #(
    parameter int INSTR_W = 18,
    parameter int DATA_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [1:0]         rd0_addr,
    output logic [1:0]         rd1_addr,
    output logic [1:0]         wr_addr,
    output logic [DATA_W:0]    wr_data,
    output logic               reg_read,
    output logic               reg_write,
    output logic               alu_src0,
    output logic               alu_src1,
    output logic [8:0]         instr_i,
    output logic [2:0]         alu_op,
    input  logic [DATA_W-1:0]  result,
    input  logic               ovf,
    input  logic               zero,
    output logic               busy,
    output logic               done,
    output logic               branch_taken,
    output logic [8:0]         branch_offset
`ifdef OVF_TRAP_EN
    ,
    output logic               ovf_trap
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_BRANCH = 3'd4
    } state_t;

    localparam logic [1:0] CLS_R   = 2'b00;
    localparam logic [1:0] CLS_I   = 2'b01;
    localparam logic [1:0] CLS_BEQ = 2'b10;
    localparam logic [1:0] CLS_LI  = 2'b11;

    // BEQ compares by subtraction regardless of the op field
    localparam logic [2:0] OP_CMP  = 3'b110;

    // Writeback is one bit wider than the ALU: replicate the sign bit
    function automatic logic [DATA_W:0] sext_result(input logic [DATA_W-1:0] r);
        return {r[DATA_W-1], r};
    endfunction

    state_t state_r;
    state_t next_state_s;

    // Latched instruction fields
    logic [1:0] cls_r;
    logic [2:0] op_r;
    logic [1:0] rd_r;
    logic [1:0] rs_r;
    logic [8:0] imm_r;

    // Fields of the instruction currently on the bus
    logic [1:0] in_cls_s;
    logic [2:0] in_op_s;
    logic [1:0] in_rd_s;
    logic [1:0] in_rs_s;
    logic [8:0] in_imm_s;

    // Fields that apply to the state being entered
    logic [1:0] f_cls_s;
    logic [2:0] f_op_s;
    logic [1:0] f_rd_s;
    logic [1:0] f_rs_s;
    logic [8:0] f_imm_s;

    logic accept_s;
    logic trap_s;

    // Next values of the registered outputs
    logic       ready_nx_s;
    logic [1:0] rd0_nx_s;
    logic [1:0] rd1_nx_s;
    logic [1:0] wr_addr_nx_s;
    logic [DATA_W:0] wr_data_nx_s;
    logic       reg_read_nx_s;
    logic       reg_write_nx_s;
    logic       src0_nx_s;
    logic       src1_nx_s;
    logic [8:0] instr_i_nx_s;
    logic [2:0] alu_op_nx_s;
    logic       busy_nx_s;
    logic       done_nx_s;
    logic       taken_nx_s;
    logic [8:0] offset_nx_s;
    logic       trap_nx_s;

    assign in_cls_s = instr[17:16];
    assign in_op_s  = instr[15:13];
    assign in_rd_s  = instr[12:11];
    assign in_rs_s  = instr[10:9];
    assign in_imm_s = instr[8:0];

    // instr_ready is only high in IDLE, so this is the whole handshake
    assign accept_s = instr_valid && instr_ready;

`ifdef OVF_TRAP_EN
    assign trap_s = ovf && ((f_cls_s == CLS_R) || (f_cls_s == CLS_I));
`else
    // Overflow is deliberately ignored in this build; the wrapped result is written
    logic unused_ovf_s;
    assign unused_ovf_s = ovf;
    assign trap_s       = 1'b0;
`endif

    // Select the fields that describe the state being entered
    always_comb begin
        if (accept_s) begin
            f_cls_s = in_cls_s;
            f_op_s  = in_op_s;
            f_rd_s  = in_rd_s;
            f_rs_s  = in_rs_s;
            f_imm_s = in_imm_s;
        end else begin
            f_cls_s = cls_r;
            f_op_s  = op_r;
            f_rd_s  = rd_r;
            f_rs_s  = rs_r;
            f_imm_s = imm_r;
        end
    end

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = ST_DECODE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if (cls_r == CLS_LI) begin
                    next_state_s = ST_WB;
                end else begin
                    next_state_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cls_r == CLS_BEQ) begin
                    next_state_s = ST_BRANCH;
                end else begin
                    next_state_s = ST_WB;
                end
            end
            ST_WB:     next_state_s = ST_IDLE;
            ST_BRANCH: next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // Output values for the state being entered; result/zero/ovf are captured
    // here on the edge that leaves EXEC
    always_comb begin
        ready_nx_s     = 1'b0;
        rd0_nx_s       = 2'b00;
        rd1_nx_s       = 2'b00;
        wr_addr_nx_s   = 2'b00;
        wr_data_nx_s   = {(DATA_W+1){1'b0}};
        reg_read_nx_s  = 1'b0;
        reg_write_nx_s = 1'b0;
        src0_nx_s      = 1'b0;
        src1_nx_s      = 1'b0;
        instr_i_nx_s   = 9'd0;
        alu_op_nx_s    = 3'b000;
        busy_nx_s      = (next_state_s != ST_IDLE);
        done_nx_s      = 1'b0;
        taken_nx_s     = 1'b0;
        offset_nx_s    = 9'd0;
        trap_nx_s      = 1'b0;
        case (next_state_s)
            ST_IDLE: begin
                ready_nx_s = 1'b1;
            end
            ST_DECODE, ST_EXEC: begin
                reg_read_nx_s = 1'b1;
                rd0_nx_s      = f_rs_s;
                case (f_cls_s)
                    CLS_R:   rd1_nx_s = f_imm_s[1:0];
                    CLS_BEQ: rd1_nx_s = f_rd_s;
                    default: rd1_nx_s = 2'b00;
                endcase
                src0_nx_s    = 1'b0;
                src1_nx_s    = (f_cls_s == CLS_I);
                instr_i_nx_s = f_imm_s;
                if (next_state_s == ST_EXEC) begin
                    if (f_cls_s == CLS_BEQ) begin
                        alu_op_nx_s = OP_CMP;
                    end else begin
                        alu_op_nx_s = f_op_s;
                    end
                end else begin
                    alu_op_nx_s = 3'b000;
                end
            end
            ST_WB: begin
                done_nx_s    = 1'b1;
                wr_addr_nx_s = f_rd_s;
                if (f_cls_s == CLS_LI) begin
                    wr_data_nx_s = f_imm_s;
                end else begin
                    wr_data_nx_s = sext_result(result);
                end
                trap_nx_s      = trap_s;
                reg_write_nx_s = !trap_s;
            end
            ST_BRANCH: begin
                done_nx_s   = 1'b1;
                taken_nx_s  = zero;
                offset_nx_s = f_imm_s;
            end
            default: begin
                ready_nx_s = 1'b0;
            end
        endcase
    end

    // State register and instruction latch
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cls_r   <= 2'b00;
            op_r    <= 3'b000;
            rd_r    <= 2'b00;
            rs_r    <= 2'b00;
            imm_r   <= 9'd0;
        end else begin
            state_r <= next_state_s;
            if (accept_s) begin
                cls_r <= in_cls_s;
                op_r  <= in_op_s;
                rd_r  <= in_rd_s;
                rs_r  <= in_rs_s;
                imm_r <= in_imm_s;
            end else begin
                cls_r <= cls_r;
                op_r  <= op_r;
                rd_r  <= rd_r;
                rs_r  <= rs_r;
                imm_r <= imm_r;
            end
        end
    end

    // Registered outputs; reset drops any pending write or done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_ready   <= 1'b1;
            rd0_addr      <= 2'b00;
            rd1_addr      <= 2'b00;
            wr_addr       <= 2'b00;
            wr_data       <= {(DATA_W+1){1'b0}};
            reg_read      <= 1'b0;
            reg_write     <= 1'b0;
            alu_src0      <= 1'b0;
            alu_src1      <= 1'b0;
            instr_i       <= 9'd0;
            alu_op        <= 3'b000;
            busy          <= 1'b0;
            done          <= 1'b0;
            branch_taken  <= 1'b0;
            branch_offset <= 9'd0;
        end else begin
            instr_ready   <= ready_nx_s;
            rd0_addr      <= rd0_nx_s;
            rd1_addr      <= rd1_nx_s;
            wr_addr       <= wr_addr_nx_s;
            wr_data       <= wr_data_nx_s;
            reg_read      <= reg_read_nx_s;
            reg_write     <= reg_write_nx_s;
            alu_src0      <= src0_nx_s;
            alu_src1      <= src1_nx_s;
            instr_i       <= instr_i_nx_s;
            alu_op        <= alu_op_nx_s;
            busy          <= busy_nx_s;
            done          <= done_nx_s;
            branch_taken  <= taken_nx_s;
            branch_offset <= offset_nx_s;
        end
    end

`ifdef OVF_TRAP_EN
    // Overflow trap pulse, coincident with done in WB
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_trap <= 1'b0;
        end else begin
            ovf_trap <= trap_nx_s;
        end
    end
`else
    logic unused_trap_nx_s;
    assign unused_trap_nx_s = trap_nx_s;
`endif

endmodule

// File: tb/tb_alu_regfile_ctrl.sv
// tb_alu_regfile_ctrl: self-checking bench for alu_regfile_ctrl with a small
// register file / ALU stub standing in for the datapath. Expected retire
// records are predicted from the instruction and a shadow register file,
// pushed to a queue on issue, and popped when the instruction retires.
module tb_alu_regfile_ctrl;

`ifdef OVF_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [17:0] instr;
    logic [1:0]  rd0_addr, rd1_addr, wr_addr;
    logic [8:0]  wr_data;
    logic        reg_read, reg_write, alu_src0, alu_src1;
    logic [8:0]  instr_i;
    logic [2:0]  alu_op;
    logic [7:0]  dp_result;
    logic        dp_ovf, dp_zero;
    logic        busy, done, branch_taken;
    logic [8:0]  branch_offset;
    logic        trap_sig;

    typedef struct packed {
        logic       we;
        logic [1:0] wa;
        logic [8:0] wd;
        logic       taken;
        logic [8:0] off;
        logic       trap;
        logic [1:0] nwr;
        logic [3:0] lat;
    } ret_t;

    ret_t       exp_q[$];
    ret_t       obs;
    logic [7:0] exp_rf [4];
    logic [7:0] rf [4];
    logic [9:0] alu_f;
    logic [7:0] op_a, op_b;
    logic [1:0] snap_rd0 [9];
    logic [1:0] snap_rd1 [9];
    logic [2:0] snap_op  [9];
    logic       snap_rr  [9];
    logic       snap_src1[9];
    logic [8:0] snap_ii  [9];
    int         last_wait;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    alu_regfile_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .rd0_addr      (rd0_addr),
        .rd1_addr      (rd1_addr),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .reg_read      (reg_read),
        .reg_write     (reg_write),
        .alu_src0      (alu_src0),
        .alu_src1      (alu_src1),
        .instr_i       (instr_i),
        .alu_op        (alu_op),
        .result        (dp_result),
        .ovf           (dp_ovf),
        .zero          (dp_zero),
        .busy          (busy),
        .done          (done),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset)
`ifdef OVF_TRAP_EN
        ,
        .ovf_trap      (trap_sig)
`endif
    );

`ifndef OVF_TRAP_EN
    assign trap_sig = 1'b0;
`endif

    // Reference ALU: returns {ovf, zero, result}
    function automatic logic [9:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic       v;
        v = 1'b0;
        case (op)
            3'b000: begin r = a + b; v = (a[7] == b[7]) && (r[7] != a[7]); end
            3'b001, 3'b110: begin r = a - b; v = (a[7] != b[7]) && (r[7] != a[7]); end
            3'b010: r = a & b;
            3'b011: r = a | b;
            3'b100: r = a ^ b;
            default: r = a;
        endcase
        return {v, (r == 8'h00), r};
    endfunction

    // Datapath stub: register file write port
    always_ff @(posedge clk) begin
        if (reg_write) rf[wr_addr] <= wr_data[7:0];
    end

    // Datapath stub: operand muxes and ALU
    always_comb begin
        op_a  = alu_src0 ? 8'h00 : rf[rd0_addr];
        op_b  = alu_src1 ? instr_i[7:0] : rf[rd1_addr];
        alu_f = alu_ref(alu_op, op_a, op_b);
    end
    assign dp_result = alu_f[7:0];
    assign dp_zero   = alu_f[8];
    assign dp_ovf    = alu_f[9];

    // Predict the retire record of one instruction and push it
    task automatic predict(input logic [17:0] ins);
        ret_t       e;
        logic [9:0] f;
        logic [1:0] cls, rd, rs;
        logic [2:0] op;
        logic [8:0] imm;
        {cls, op, rd, rs, imm} = ins;
        e = '0;
        e.lat = 4'd3;
        case (cls)
            2'b11: begin
                e.we = 1'b1; e.wa = rd; e.wd = imm; e.nwr = 2'd1; e.lat = 4'd2;
                exp_rf[rd] = imm[7:0];
            end
            2'b10: begin
                f = alu_ref(3'b110, exp_rf[rs], exp_rf[rd]);
                e.taken = f[8]; e.off = imm;
            end
            default: begin
                f = alu_ref(op, exp_rf[rs], (cls == 2'b00) ? exp_rf[imm[1:0]] : imm[7:0]);
                if (TRAP && f[9]) begin
                    e.trap = 1'b1;
                end else begin
                    e.we = 1'b1; e.wa = rd; e.wd = {f[7], f[7:0]}; e.nwr = 2'd1;
                    exp_rf[rd] = f[7:0];
                end
            end
        endcase
        exp_q.push_back(e);
    endtask

    // Issue one instruction and record what the controller does until done
    task automatic send(input logic [17:0] ins);
        int t;
        bit is_br;
        predict(ins);
        is_br = (ins[17:16] == 2'b10);
        @(negedge clk);
        t = 0;
        while (!instr_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        last_wait = t;
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr = 18'($urandom);
        obs = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            snap_rd0[c] = rd0_addr; snap_rd1[c] = rd1_addr; snap_op[c] = alu_op;
            snap_rr[c] = reg_read; snap_src1[c] = alu_src1; snap_ii[c] = instr_i;
            if (reg_write) begin
                obs.we = 1'b1; obs.wa = wr_addr; obs.wd = wr_data; obs.nwr = obs.nwr + 2'd1;
            end
            if (done) begin
                obs.lat = 4'(c);
                obs.taken = branch_taken;
                if (is_br) obs.off = branch_offset;
                obs.trap = trap_sig;
                break;
            end
        end
        if (obs.lat == 4'd0) obs.lat = 4'hF;
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_valid = 1'b0; instr = 18'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({instr_ready, busy, done, reg_write, reg_read} !== 5'b10000) begin
            $display("FAIL reset_ctrl: got %b expected %b", {instr_ready, busy, done, reg_write, reg_read}, 5'b10000);
            n_bad++;
        end
        n_cmp++;
        if ({wr_data, wr_addr, rd0_addr, rd1_addr, alu_op, instr_i, branch_taken, branch_offset, alu_src0, alu_src1, trap_sig} !== 40'd0) begin
            $display("FAIL reset_data: got %h expected 0",
                     {wr_data, wr_addr, rd0_addr, rd1_addr, alu_op, instr_i, branch_taken, branch_offset, alu_src0, alu_src1, trap_sig});
            n_bad++;
        end
    endtask

    task automatic test_li();
        ret_t e;
        logic [17:0] loads [4];
        loads[0] = {2'b11, 3'b000, 2'd3, 2'd0, 9'h07F};
        loads[1] = {2'b11, 3'b000, 2'd0, 2'd0, 9'h000};
        loads[2] = {2'b11, 3'b000, 2'd1, 2'd0, 9'h055};
        loads[3] = {2'b11, 3'b000, 2'd2, 2'd0, 9'h0AA};
        for (int i = 0; i < 4; i++) begin
            send(loads[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                $display("FAIL li_%0d: got %h expected %h", i, obs, e);
                n_bad++;
            end
            if (i == 0) begin
                @(negedge clk);
                n_cmp++;
                if ({instr_ready, done, reg_write} !== 3'b100) begin
                    $display("FAIL li_after: got %b expected %b", {instr_ready, done, reg_write}, 3'b100);
                    n_bad++;
                end
            end
        end
    endtask

    task automatic test_r_and();
        ret_t e;
        send({2'b00, 3'b010, 2'd0, 2'd1, 9'd2});
        e = exp_q.pop_front();
        n_cmp++;
        if ({snap_rd0[2], snap_rd1[2], snap_op[2], snap_rr[2], snap_src1[2]} !== {2'd1, 2'd2, 3'b010, 1'b1, 1'b0}) begin
            $display("FAIL r_and_exec: got %h expected %h",
                     {snap_rd0[2], snap_rd1[2], snap_op[2], snap_rr[2], snap_src1[2]}, {2'd1, 2'd2, 3'b010, 1'b1, 1'b0});
            n_bad++;
        end
        n_cmp++;
        if (obs !== e) begin
            $display("FAIL r_and_wb: got %h expected %h", obs, e);
            n_bad++;
        end
    endtask

    task automatic test_i_add();
        ret_t e;
        send({2'b01, 3'b000, 2'd3, 2'd0, 9'd15});
        e = exp_q.pop_front();
        n_cmp++;
        if ({snap_src1[2], snap_ii[2], snap_op[2]} !== {1'b1, 9'd15, 3'b000}) begin
            $display("FAIL i_add_exec: got %h expected %h", {snap_src1[2], snap_ii[2], snap_op[2]}, {1'b1, 9'd15, 3'b000});
            n_bad++;
        end
        n_cmp++;
        if (obs !== e) begin
            $display("FAIL i_add_wb: got %h expected %h", obs, e);
            n_bad++;
        end
    endtask

    task automatic test_beq();
        ret_t e;
        logic [17:0] br [2];
        br[0] = {2'b10, 3'b001, 2'd1, 2'd1, 9'h1FC};
        br[1] = {2'b10, 3'b001, 2'd1, 2'd2, 9'h1FC};
        for (int i = 0; i < 2; i++) begin
            send(br[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (snap_op[2] !== 3'b110) begin
                $display("FAIL beq_op_%0d: got %b expected 110", i, snap_op[2]);
                n_bad++;
            end
            n_cmp++;
            if (obs !== e) begin
                $display("FAIL beq_%0d: got %h expected %h", i, obs, e);
                n_bad++;
            end
        end
    endtask

    task automatic test_ovf();
        ret_t e;
        send({2'b11, 3'b000, 2'd3, 2'd0, 9'h07F});
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            $display("FAIL ovf_load: got %h expected %h", obs, e);
            n_bad++;
        end
        send({2'b00, 3'b000, 2'd2, 2'd3, 9'd1});
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            $display("FAIL ovf_add: got %h expected %h", obs, e);
            n_bad++;
        end
`ifdef OVF_TRAP_EN
        n_cmp++;
        if ({obs.trap, obs.nwr} !== {1'b1, 2'd0}) begin
            $display("FAIL ovf_trap: got %b expected %b", {obs.trap, obs.nwr}, {1'b1, 2'd0});
            n_bad++;
        end
`else
        n_cmp++;
        if (obs.wd !== 9'h1D4) begin
            $display("FAIL ovf_wrap: got %h expected 1d4", obs.wd);
            n_bad++;
        end
`endif
    endtask

    task automatic test_reset_exec();
        int seen;
        @(negedge clk);
        instr = {2'b00, 3'b000, 2'd0, 2'd1, 9'd2};
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, alu_op} !== {1'b1, 3'b000}) begin
            $display("FAIL rst_exec_pre: got %b expected %b", {busy, alu_op}, {1'b1, 3'b000});
            n_bad++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        n_cmp++;
        if ({instr_ready, busy, done, reg_write} !== 4'b1000) begin
            $display("FAIL rst_exec_idle: got %b expected %b", {instr_ready, busy, done, reg_write}, 4'b1000);
            n_bad++;
        end
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || reg_write) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            $display("FAIL rst_exec_quiet: got %0d done/write cycles expected 0", seen);
            n_bad++;
        end
    endtask

    task automatic test_back_to_back();
        ret_t e;
        int worst;
        logic [17:0] ins;
        worst = 0;
        for (int i = 0; i < 16; i++) begin
            ins = {2'($urandom_range(0, 3)), 3'($urandom_range(0, 4)), 2'($urandom), 2'($urandom), 9'($urandom)};
            send(ins);
            if (last_wait > worst) worst = last_wait;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                $display("FAIL b2b_%0d (instr %h): got %h expected %h", i, ins, obs, e);
                n_bad++;
            end
        end
        n_cmp++;
        if (worst !== 0) begin
            $display("FAIL b2b_ready: got %0d wait cycles expected 0", worst);
            n_bad++;
        end
    endtask

    initial begin
        test_reset();
        test_li();
        test_r_and();
        test_i_add();
        test_beq();
        test_ovf();
        test_reset_exec();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Bound the whole run
    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

endmodule
